// File: rtl/unidade_controle_pkg.sv
// -----------------------------------------------------------------------------
// unidade_controle_pkg
// Shared encodings for the multicycle control unit and the ULA:
//   - OP_*    : 3-bit opcodes taken from Instrucao[7:5]
//   - ULA_*   : 2-bit UlaOp codes consumed by the ULA
//   - estado_t: FSM state encoding of unidade_controle
// -----------------------------------------------------------------------------
package unidade_controle_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_BEQ   = 3'b010;
  localparam logic [2:0] OP_BPAR  = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_JUMP  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ULA_ADD = 2'b10;
  localparam logic [1:0] ULA_SUB = 2'b01;
  localparam logic [1:0] ULA_CMP = 2'b00;
  localparam logic [1:0] ULA_PAR = 2'b11;

  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    ESCRITA    = 3'd3,
    MEMORIA    = 3'd4,
    DESVIO     = 3'd5,
    PARADO     = 3'd6
  } estado_t;

endpackage

// File: rtl/unidade_controle.sv
// -----------------------------------------------------------------------------
// unidade_controle
// Multicycle control FSM for the 8-bit datapath. Sequences fetch, decode,
// execute/memory and write-back/branch steps, drives the ULA operation and
// the register/memory/PC strobes, and counts retired instructions.
//
// Optional build macro: MEM_ESPERA_EN adds input MemPronto; BUSCA and MEMORIA
// then wait (holding their strobes) until memory signals ready.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   MemPronto      in   memory ready (only with MEM_ESPERA_EN)
//   Instrucao[7:0] in   IR contents, opcode = Instrucao[7:5]
//   Zero           in   ULA equality flag (used only in DESVIO)
//   Sip            in   ULA "Dado1 even" flag (used only in DESVIO)
//   UlaOp[1:0]     out  ULA operation select
//   PCWrite        out  load PC
//   PCSrc          out  0 = PC+1, 1 = branch/jump target
//   IRWrite        out  load IR from memory
//   MemRead        out  memory read strobe
//   MemWrite       out  memory write strobe
//   RegWrite       out  register-file write enable
//   MemToReg       out  write-back source (1 = memory data)
//   Parado         out  high while halted
//   InstrRetiradas out  retired-instruction count, wraps
// -----------------------------------------------------------------------------
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
`ifdef MEM_ESPERA_EN
  input  logic                 MemPronto,
`endif
  input  logic [7:0]           Instrucao,
  input  logic                 Zero,
  input  logic                 Sip,
  output logic [1:0]           UlaOp,
  output logic                 PCWrite,
  output logic                 PCSrc,
  output logic                 IRWrite,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 MemToReg,
  output logic                 Parado,
  output logic [CNT_WIDTH-1:0] InstrRetiradas
);

  estado_t    estado;
  estado_t    proximo;
  logic [2:0] opcode;
  logic       mem_pronto;
  logic       retira;

  // Only the opcode field of the instruction matters to control.
  logic unused_campos;
  assign unused_campos = ^Instrucao[4:0];

`ifdef MEM_ESPERA_EN
  assign mem_pronto = MemPronto;
`else
  assign mem_pronto = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado         <= BUSCA;
      opcode         <= OP_ADD;
      InstrRetiradas <= '0;
    end else begin
      estado <= proximo;
      if (estado == DECODIFICA) opcode <= Instrucao[7:5];
      if (retira) InstrRetiradas <= InstrRetiradas + CNT_WIDTH'(1);
    end
  end

  // Next state and retire pulse. Retire marks the edge that leaves the last
  // state of an instruction; HALT retires on its way into PARADO.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    proximo = estado;
    retira  = 1'b0;
    unique case (estado)
      BUSCA: if (mem_pronto) proximo = DECODIFICA;
      DECODIFICA: begin
        unique case (Instrucao[7:5])
          OP_ADD, OP_SUB:            proximo = EXECUTA;
          OP_LOAD, OP_STORE:         proximo = MEMORIA;
          OP_BEQ, OP_BPAR, OP_JUMP:  proximo = DESVIO;
          default: begin
            proximo = PARADO;
            retira  = 1'b1;
          end
        endcase
      end
      EXECUTA: proximo = ESCRITA;
      ESCRITA: begin
        proximo = BUSCA;
        retira  = 1'b1;
      end
      MEMORIA: begin
        if (mem_pronto) begin
          if (opcode == OP_LOAD) begin
            proximo = ESCRITA;
          end else begin
            proximo = BUSCA;
            retira  = 1'b1;
          end
        end
      end
      DESVIO: begin
        proximo = BUSCA;
        retira  = 1'b1;
      end
      PARADO: proximo = PARADO;
      default: proximo = BUSCA;
    endcase
  end

  // Output decode from registered state and latched opcode. Reset forces
  // every strobe low in the reset cycle itself, regardless of the old state.
  always_comb begin
    UlaOp    = ULA_CMP;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    Parado   = 1'b0;
    if (!reset) begin
      unique case (estado)
        BUSCA: begin
          MemRead = 1'b1;
          // IR and PC load only on the cycle the fetched word is valid.
          IRWrite = mem_pronto;
          PCWrite = mem_pronto;
        end
        EXECUTA: UlaOp = (opcode == OP_SUB) ? ULA_SUB : ULA_ADD;
        ESCRITA: begin
          RegWrite = 1'b1;
          // Keep the EXECUTA op so the combinational result stays stable.
          if (opcode == OP_ADD)      UlaOp = ULA_ADD;
          else if (opcode == OP_SUB) UlaOp = ULA_SUB;
          MemToReg = (opcode == OP_LOAD);
        end
        MEMORIA: begin
          MemRead  = (opcode == OP_LOAD);
          MemWrite = (opcode == OP_STORE);
        end
        DESVIO: begin
          PCSrc = 1'b1;
          if (opcode == OP_BEQ) begin
            UlaOp   = ULA_CMP;
            PCWrite = Zero;
          end else if (opcode == OP_BPAR) begin
            UlaOp   = ULA_PAR;
            PCWrite = Sip;
          end else begin
            PCWrite = 1'b1;
          end
        end
        PARADO: Parado = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
Multicycle control FSM for the 8-bit datapath. It drives UlaOp into the ULA and consumes the ULA's Zero and Sip flags. It sequences the steps of each instruction (fetch, decode, execute/memory, write-back/branch) and issues register, memory and PC strobes. It also keeps a count of retired instructions.

Parameters:
CNT_WIDTH, 16, width of the retired-instruction counter InstrRetiradas.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
Instrucao  input  8  IR contents; opcode = Instrucao[7:5]; valid from DECODIFICA onward.
Zero  input  1  ULA equality flag, combinational, same cycle.
Sip  input  1  ULA "Dado1 even" flag, combinational, same cycle.
UlaOp  output  2  ULA op: 10 add, 01 sub, 00 compare, 11 parity test.
PCWrite  output  1  load PC.
PCSrc  output  1  0 = PC+1, 1 = branch/jump target.
IRWrite  output  1  load IR from memory.
MemRead  output  1  memory read strobe.
MemWrite  output  1  memory write strobe.
RegWrite  output  1  register-file write enable.
MemToReg  output  1  write-back source: 0 = ULA Resultado, 1 = memory data.
Parado  output  1  high while halted.
InstrRetiradas  output  CNT_WIDTH  retired-instruction count.

Behaviour:
- Opcodes:
  - 000 ADD, 001 SUB, 010 BEQ, 011 BPAR (branch if Sip).
  - 100 LOAD, 101 STORE, 110 JUMP, 111 HALT.
- States: BUSCA, DECODIFICA, EXECUTA, ESCRITA, MEMORIA, DESVIO, PARADO.
- Reset (any cycle, including mid-instruction):
  - state goes to BUSCA.
  - InstrRetiradas goes to 0.
  - Opcode register goes to 000.
  - All strobes are 0 in the reset cycle; UlaOp is 00.
- Outputs are decoded from the registered state plus the latched opcode only, except PCWrite in DESVIO. Every strobe defaults to 0 and UlaOp defaults to 00.
- BUSCA: MemRead=1, IRWrite=1, PCWrite=1, PCSrc=0. Next state is DECODIFICA.
- DECODIFICA: no strobes. Instrucao[7:5] is latched into the opcode register. Next state:
  - ADD/SUB → EXECUTA.
  - LOAD/STORE → MEMORIA.
  - BEQ/BPAR/JUMP → DESVIO.
  - HALT → PARADO.
- EXECUTA: UlaOp = 10 (ADD) or 01 (SUB). Next state is ESCRITA.
- ESCRITA:
  - RegWrite=1.
  - UlaOp is held at the EXECUTA value, because the ULA result is combinational and undefined for compare ops.
  - MemToReg=1 only for LOAD.
  - Next state is BUSCA.
- MEMORIA: LOAD gives MemRead=1 and next state ESCRITA. STORE gives MemWrite=1 and next state BUSCA.
- DESVIO: PCSrc=1, next state BUSCA.
  - BEQ: UlaOp=00, PCWrite=Zero.
  - BPAR: UlaOp=11, PCWrite=Sip.
  - JUMP: PCWrite=1.
- PARADO: Parado=1, no strobes. The FSM stays in PARADO until reset.
- Latency in cycles:
  - ADD/SUB/LOAD: 4.
  - STORE/BEQ/BPAR/JUMP: 3.
  - HALT: 2, then halted.
- InstrRetiradas increments by 1 on the edge leaving the final state of each instruction. A not-taken branch still counts. HALT counts once, on entry to PARADO.
- The counter wraps modulo 2^CNT_WIDTH with no saturation.
- Zero/Sip are ignored outside DESVIO.

Optional Feature:
MEM_ESPERA_EN
- Defined:
  - Adds input MemPronto (1 bit).
  - BUSCA and MEMORIA stay in place, holding all their strobes, until MemPronto=1.
  - IRWrite and PCWrite in BUSCA assert only in the cycle where MemPronto=1.
  - Reset still overrides at once.
- Undefined: MemPronto does not exist and memory is treated as single-cycle.

Decomposition:
- Package unidade_controle_pkg holds:
  - the opcode localparams (OP_ADD..OP_HALT);
  - the ULA op constants (ULA_ADD=10, ULA_SUB=01, ULA_CMP=00, ULA_PAR=11);
  - the estado_t enum.
- The ULA should adopt the ULA_* constants from this package.
- No sub-module: one FSM with a next-state block and an output-decode block.

Test Plan:
- Reset, then ADD (Instrucao=8'h00):
  - BUSCA cycle: MemRead=IRWrite=PCWrite=1.
  - Two cycles later: UlaOp=10.
  - Next cycle: RegWrite=1, MemToReg=0.
  - InstrRetiradas=1 after 4 cycles.
- BEQ (8'h40) with Zero=1 → DESVIO has UlaOp=00, PCSrc=1, PCWrite=1. Repeat with Zero=0 → PCWrite=0, counter still increments.
- BPAR (8'h60) with Sip=1 → PCWrite=1. With Sip=0 → PCWrite=0. Total 3 cycles.
- LOAD (8'h80) → MEMORIA MemRead=1, then ESCRITA RegWrite=1, MemToReg=1. STORE (8'hA0) → one MemWrite pulse, back to BUSCA in 3 cycles.
- HALT (8'hE0) → Parado=1 with no strobes for 20 cycles. Assert reset → BUSCA, counter=0.
- Reset asserted during EXECUTA of SUB → next cycle in BUSCA, RegWrite never asserted. With MEM_ESPERA_EN, MemPronto=0 for 3 cycles → state holds in BUSCA, with IRWrite=0 and PCWrite=0 until MemPronto=1.
